data_memory_ctrl: RTL and testbench

Parametrised, byte-addressable data memory for the MIPS datapath, replacing the fixed 64-word word-only store. It supports byte, halfword and word loads and stores, with sign or zero extension on loads and detection of misaligned accesses. Read latency is configurable and pipelined, and a valid/ready handshake is provided. After every reset it clears its own contents before accepting requests.

---
 rtl/data_memory_ctrl.sv | 151 +++++++++++++++
 tb/tb_data_memory_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory for the MIPS datapath: byte/half/word access,
// load extension, misalignment rejection, self-clear after reset and a pipelined read path.
module data_memory_ctrl #(
   parameter int ADDR_WIDTH   = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic                  Clock,
   input  logic                  ResetN,
   input  logic                  Request,
   input  logic                  Write,
   input  logic [1:0]            Size,
   input  logic                  Unsigned,
   input  logic [ADDR_WIDTH-1:0] Address,
   input  logic [31:0]           WriteData,
   output logic                  Ready,
   output logic [31:0]           ReadData,
   output logic                  ReadValid,
   output logic                  Misaligned
);

   localparam int WORD_W = ADDR_WIDTH - 2;
   localparam int DEPTH  = 1 << WORD_W;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t            state, state_next;
   logic [WORD_W-1:0] clear_cnt;
   logic [31:0]       mem [DEPTH];

   logic [WORD_W-1:0] word_idx;
   logic [1:0]        lane;
   logic              accept, bad_align, is_store, is_load;
   logic [31:0]       load_word;

   logic [31:0]       rd_data_p [READ_LATENCY];
   logic              rd_vld_p  [READ_LATENCY];
   logic              misaligned_p0;

   // Builds the new word for a store: only the addressed lanes take fresh data.
   function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  ln,
                                               input logic [1:0]  sz);
      logic [3:0]  be;
      logic [31:0] src;
      logic [31:0] res;
      case (sz)
         2'b00: begin
            be  = 4'b0001 << ln;
            src = {4{wdata[7:0]}};
         end
         2'b01: begin
            be  = ln[1] ? 4'b1100 : 4'b0011;
            src = {2{wdata[15:0]}};
         end
         default: begin
            be  = 4'b1111;
            src = wdata;
         end
      endcase
      for (int k = 0; k < 4; k++)
         res[8*k +: 8] = be[k] ? src[8*k +: 8] : old_word[8*k +: 8];
      return res;
   endfunction

   // Moves the addressed lane(s) down to bit 0 and extends to 32 bits.
   function automatic logic [31:0] extend_load(input logic [31:0] word,
                                               input logic [1:0]  ln,
                                               input logic [1:0]  sz,
                                               input logic        uns);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {ln, 3'b000};
      case (sz)
         2'b00:   res = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'b01:   res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: res = word;
      endcase
      return res;
   endfunction

   assign word_idx  = Address[ADDR_WIDTH-1:2];
   assign lane      = Address[1:0];
   assign accept    = ResetN && Request && Ready;
   assign is_store  = accept && Write && !bad_align;
   assign is_load   = accept && !Write && !bad_align;
   assign load_word = mem[word_idx];

   always_comb begin
      bad_align = 1'b0;
      case (Size)
         2'b00:   bad_align = 1'b0;
         2'b01:   bad_align = lane[0];
         2'b10:   bad_align = |lane;
         default: bad_align = 1'b1;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!ResetN) state <= CLEAR;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      Ready      = 1'b0;
      case (state)
         CLEAR: if (&clear_cnt) state_next = RUN;
         RUN:   Ready = 1'b1;
         default: state_next = CLEAR;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!ResetN)             clear_cnt <= '0;
      else if (state == CLEAR) clear_cnt <= clear_cnt + 1'b1;
   end

   // Single write port shared by the clear sweep and accepted stores.
   always_ff @(posedge Clock) begin
      if (ResetN) begin
         if (state == CLEAR) mem[clear_cnt] <= '0;
         else if (is_store)  mem[word_idx]  <= merge_store(load_word, WriteData, lane, Size);
      end
   end

   // Stage 0: extended load result captured at the accept edge
   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            rd_vld_p[i]  <= 1'b0;
            rd_data_p[i] <= '0;
         end
         misaligned_p0 <= 1'b0;
      end else begin
         rd_vld_p[0]   <= is_load;
         misaligned_p0 <= accept && bad_align;
         if (is_load) rd_data_p[0] <= extend_load(load_word, lane, Size, Unsigned);
         // Later stages: data only advances with a valid, so the last stage holds its value
         for (int i = 1; i < READ_LATENCY; i++) begin
            rd_vld_p[i] <= rd_vld_p[i-1];
            if (rd_vld_p[i-1]) rd_data_p[i] <= rd_data_p[i-1];
         end
      end
   end

   assign ReadValid  = rd_vld_p[READ_LATENCY-1];
   assign ReadData   = rd_data_p[READ_LATENCY-1];
   assign Misaligned = misaligned_p0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl with a 3-cycle read pipeline.
module tb_data_memory_ctrl;

   localparam int LAT = 3;

   logic        Clock = 1'b0;
   logic        ResetN = 1'b0;
   logic        Request = 1'b0;
   logic        Write = 1'b0;
   logic [1:0]  Size = 2'b10;
   logic        Unsigned = 1'b0;
   logic [7:0]  Address = '0;
   logic [31:0] WriteData = '0;
   logic        Ready;
   logic [31:0] ReadData;
   logic        ReadValid;
   logic        Misaligned;

   int n_cmp = 0;
   int n_bad = 0;

   data_memory_ctrl #(.ADDR_WIDTH(8), .READ_LATENCY(LAT)) dut (
      .Clock(Clock), .ResetN(ResetN), .Request(Request), .Write(Write),
      .Size(Size), .Unsigned(Unsigned), .Address(Address), .WriteData(WriteData),
      .Ready(Ready), .ReadData(ReadData), .ReadValid(ReadValid), .Misaligned(Misaligned)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Waits for Ready after reset release; returns the number of edges spent clearing.
   task automatic wait_clear(output int n);
      n = 0;
      while (!Ready && n < 200) begin
         @(negedge Clock);
         n++;
      end
   endtask

   task automatic do_store(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] d,
                           output logic mis);
      @(negedge Clock);
      Request = 1'b1; Write = 1'b1; Size = sz; Address = a; WriteData = d;
      @(negedge Clock);
      Request = 1'b0; Write = 1'b0;
      mis = Misaligned;
   endtask

   // lat is the cycle (1 = cycle after accept) where ReadValid was seen, -1 if never.
   task automatic do_load(input logic [7:0] a, input logic [1:0] sz, input logic u,
                          output logic [31:0] d, output int lat, output logic mis);
      @(negedge Clock);
      Request = 1'b1; Write = 1'b0; Size = sz; Unsigned = u; Address = a;
      @(negedge Clock);
      Request = 1'b0;
      mis = Misaligned;
      lat = 1;
      while (!ReadValid && lat < 8) begin
         @(negedge Clock);
         lat++;
      end
      d = ReadData;
      if (!ReadValid) lat = -1;
   endtask

   initial begin
      logic [31:0] d;
      int          lat;
      int          n;
      logic        mis;
      logic        seen;

      // Reset and clear sweep
      repeat (3) @(negedge Clock);
      chk("rst Ready", {31'b0, Ready}, 32'd0);
      chk("rst ReadData", ReadData, 32'd0);
      chk("rst ReadValid", {31'b0, ReadValid}, 32'd0);
      chk("rst Misaligned", {31'b0, Misaligned}, 32'd0);
      ResetN = 1'b1;
      wait_clear(n);
      chk("clear cycles", n, 32'd64);

      do_load(8'h00, 2'b10, 1'b0, d, lat, mis);
      chk("load 0x00", d, 32'h0);
      chk("load latency", lat, LAT);
      chk("load 0x00 mis", {31'b0, mis}, 32'd0);
      do_load(8'hFC, 2'b10, 1'b0, d, lat, mis);
      chk("load 0xFC", d, 32'h0);

      // Partial stores and extension
      do_store(8'h10, 2'b10, 32'h11223344, mis);
      chk("store word mis", {31'b0, mis}, 32'd0);
      do_store(8'h11, 2'b00, 32'hFFFF_FFAB, mis);
      do_store(8'h12, 2'b01, 32'h1234_BEEF, mis);
      do_load(8'h10, 2'b10, 1'b0, d, lat, mis);
      chk("merged word", d, 32'hBEEFAB44);
      do_load(8'h11, 2'b00, 1'b0, d, lat, mis);
      chk("lb 0x11", d, 32'hFFFFFFAB);
      do_load(8'h11, 2'b00, 1'b1, d, lat, mis);
      chk("lbu 0x11", d, 32'h000000AB);
      do_load(8'h12, 2'b01, 1'b0, d, lat, mis);
      chk("lh 0x12", d, 32'hFFFFBEEF);
      do_load(8'h12, 2'b01, 1'b1, d, lat, mis);
      chk("lhu 0x12", d, 32'h0000BEEF);
      do_load(8'h10, 2'b00, 1'b0, d, lat, mis);
      chk("lb 0x10", d, 32'h00000044);
      do_load(8'h10, 2'b01, 1'b0, d, lat, mis);
      chk("lh 0x10", d, 32'hFFFFAB44);

      // Misaligned accesses
      do_store(8'h21, 2'b10, 32'hDEADBEEF, mis);
      chk("sw 0x21 mis", {31'b0, mis}, 32'd1);
      do_load(8'h20, 2'b10, 1'b0, d, lat, mis);
      chk("word 0x20 unchanged", d, 32'h0);
      do_load(8'h23, 2'b01, 1'b0, d, lat, mis);
      chk("lh 0x23 mis", {31'b0, mis}, 32'd1);
      chk("lh 0x23 no valid", lat, -1);
      do_load(8'h00, 2'b11, 1'b0, d, lat, mis);
      chk("size 11 mis", {31'b0, mis}, 32'd1);
      chk("size 11 no valid", lat, -1);

      // Back-to-back loads through the pipeline
      for (int k = 0; k < 4; k++) do_store(8'(4 * k), 2'b10, 32'(4 * k), mis);
      @(negedge Clock);
      Request = 1'b1; Write = 1'b0; Size = 2'b10; Address = 8'h00;
      for (int j = 1; j <= 8; j++) begin
         @(negedge Clock);
         chk($sformatf("pipe vld c%0d", j), {31'b0, ReadValid}, {31'b0, (j >= 3 && j <= 6)});
         if (j >= 3 && j <= 6) chk($sformatf("pipe data c%0d", j), ReadData, 32'(4 * (j - 3)));
         if (j < 4) Address = 8'(4 * j);
         else       Request = 1'b0;
      end

      // Store immediately followed by a load of the same word
      @(negedge Clock);
      Request = 1'b1; Write = 1'b1; Size = 2'b10; Address = 8'h40; WriteData = 32'h5;
      @(negedge Clock);
      Write = 1'b0;
      @(negedge Clock);
      Request = 1'b0;
      lat = 1;
      while (!ReadValid && lat < 8) begin
         @(negedge Clock);
         lat++;
      end
      chk("st->ld valid", {31'b0, ReadValid}, 32'd1);
      chk("st->ld data", ReadData, 32'h5);

      // Reset with a load in flight
      @(negedge Clock);
      Request = 1'b1; Write = 1'b0; Size = 2'b10; Address = 8'h40;
      @(negedge Clock);
      Request = 1'b0; ResetN = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge Clock);
         if (ReadValid) seen = 1'b1;
      end
      chk("flushed load", {31'b0, seen}, 32'd0);
      chk("midrst ReadData", ReadData, 32'd0);
      ResetN = 1'b1;
      wait_clear(n);
      chk("reclear cycles", n, 32'd64);
      do_load(8'h40, 2'b10, 1'b0, d, lat, mis);
      chk("0x40 cleared", d, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
